// File: rtl/alu_defs_pkg.sv
// Shared definitions for the execute stage: ALU operation codes,
// forwarding-select encodings and the immediate-extension rule.
package alu_defs;

  localparam logic [5:0] OP_SLL  = 6'b000000;
  localparam logic [5:0] OP_SRL  = 6'b000010;
  localparam logic [5:0] OP_SRA  = 6'b000011;
  localparam logic [5:0] OP_SLLV = 6'b000100;
  localparam logic [5:0] OP_SRLV = 6'b000110;
  localparam logic [5:0] OP_SRAV = 6'b000111;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_ADD  = 6'b100000;
  localparam logic [5:0] OP_ADDU = 6'b100001;
  localparam logic [5:0] OP_SUB  = 6'b100010;
  localparam logic [5:0] OP_SUBU = 6'b100011;
  localparam logic [5:0] OP_AND  = 6'b100100;
  localparam logic [5:0] OP_OR   = 6'b100101;
  localparam logic [5:0] OP_XOR  = 6'b100110;
  localparam logic [5:0] OP_NOR  = 6'b100111;
  localparam logic [5:0] OP_SLT  = 6'b101010;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  // Logical immediates are zero-extended; everything else sign-extends.
  function automatic logic is_zero_ext(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU. Shifts operate on the forwarded register
// operand (bf); all other operations use the post-immediate-mux b.
module alu_core
  import alu_defs::*;
#(
  parameter int BITS_DATA = 32
) (
  input  logic [BITS_DATA-1:0] a,
  input  logic [BITS_DATA-1:0] bf,
  input  logic [BITS_DATA-1:0] b,
  input  logic [5:0]           op,
  input  logic                 shamt,
  input  logic [4:0]           shamt_field,
  output logic [BITS_DATA-1:0] result,
  output logic                 overflow,
  output logic                 illegal
);

  localparam int MSB = BITS_DATA - 1;

  logic [BITS_DATA-1:0] sum;
  logic [BITS_DATA-1:0] diff;
  logic [4:0]           sh_fixed;

  assign sum      = a + b;
  assign diff     = a - b;
  // Fixed shifts use the instruction field when flagged, otherwise A[4:0].
  assign sh_fixed = shamt ? shamt_field : a[4:0];

  // Operation select, signed-overflow detection and unknown-op flagging.
  always_comb begin
    result   = '0;
    overflow = 1'b0;
    illegal  = 1'b0;
    case (op)
      OP_ADD: begin
        result   = sum;
        overflow = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_ADDU: result = sum;
      OP_SUB: begin
        result   = diff;
        overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      OP_SUBU:          result = diff;
      OP_AND, OP_ANDI:  result = a & b;
      OP_OR,  OP_ORI:   result = a | b;
      OP_XOR, OP_XORI:  result = a ^ b;
      OP_NOR:           result = ~(a | b);
      OP_SLT, OP_SLTI:  result = {{(BITS_DATA-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL:           result = bf << sh_fixed;
      OP_SRL:           result = bf >> sh_fixed;
      OP_SRA:           result = BITS_DATA'($signed(bf) >>> sh_fixed);
      OP_SLLV:          result = bf << a[4:0];
      OP_SRLV:          result = bf >> a[4:0];
      OP_SRAV:          result = BITS_DATA'($signed(bf) >>> a[4:0]);
      default:          illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ex_stage.sv
// MIPS execute stage: operand forwarding, immediate extension, ALU and
// the EX/MEM pipeline register.
//
// Handshake: there is no backpressure port. o_valid=1 means the EX/MEM
// register holds a real instruction; i_stall freezes it, i_flush loads a
// bubble (o_valid=0), and i_reset clears it. Priority is
// reset > flush > stall > load on every rising edge.
module alu_ex_stage
  import alu_defs::*;
#(
  parameter int BITS_DATA = 32,
  parameter int BITS_REG  = 5,
  parameter int BITS_IMM  = 16,
  parameter int ALU_OP    = 6
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_stall,
  input  logic                 i_flush,
  input  logic [ALU_OP-1:0]    i_alu_op,
  input  logic                 i_shamt,
  input  logic [4:0]           i_shamt_field,
  input  logic                 i_alu_src,
  input  logic [BITS_IMM-1:0]  i_imm,
  input  logic [BITS_DATA-1:0] i_rs_data,
  input  logic [BITS_DATA-1:0] i_rt_data,
  input  logic [BITS_DATA-1:0] i_wb_data,
  input  logic [1:0]           i_fwd_a,
  input  logic [1:0]           i_fwd_b,
  input  logic                 i_reg_write,
  input  logic                 i_mem_read,
  input  logic                 i_mem_write,
  input  logic                 i_mem_to_reg,
  input  logic [BITS_REG-1:0]  i_rd_addr,
  output logic [BITS_DATA-1:0] o_result,
  output logic [BITS_DATA-1:0] o_store_data,
  output logic                 o_reg_write,
  output logic                 o_mem_read,
  output logic                 o_mem_write,
  output logic                 o_mem_to_reg,
  output logic [BITS_REG-1:0]  o_rd_addr,
  output logic                 o_overflow,
  output logic                 o_illegal,
  output logic                 o_valid
);

  logic [BITS_DATA-1:0] op_a;
  logic [BITS_DATA-1:0] op_bf;
  logic [BITS_DATA-1:0] op_b;
  logic [BITS_DATA-1:0] imm_ext;
  logic [BITS_DATA-1:0] alu_result;
  logic                 alu_overflow;
  logic                 alu_illegal;

  // Forwarding muxes; 01 reads the registered result, so no comb loop.
  always_comb begin
    op_a = i_rs_data;
    case (i_fwd_a)
      FWD_EXMEM: op_a = o_result;
      FWD_MEMWB: op_a = i_wb_data;
      default:   op_a = i_rs_data;
    endcase
    op_bf = i_rt_data;
    case (i_fwd_b)
      FWD_EXMEM: op_bf = o_result;
      FWD_MEMWB: op_bf = i_wb_data;
      default:   op_bf = i_rt_data;
    endcase
  end

  // Immediate extension and operand-B select.
  always_comb begin
    if (is_zero_ext(i_alu_op))
      imm_ext = {{(BITS_DATA-BITS_IMM){1'b0}}, i_imm};
    else
      imm_ext = {{(BITS_DATA-BITS_IMM){i_imm[BITS_IMM-1]}}, i_imm};
    op_b = i_alu_src ? imm_ext : op_bf;
  end

  alu_core #(
    .BITS_DATA(BITS_DATA)
  ) u_alu_core (
    .a           (op_a),
    .bf          (op_bf),
    .b           (op_b),
    .op          (i_alu_op),
    .shamt       (i_shamt),
    .shamt_field (i_shamt_field),
    .result      (alu_result),
    .overflow    (alu_overflow),
    .illegal     (alu_illegal)
  );

  // EX/MEM register: reset > flush > stall > load.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      o_result     <= '0;
      o_store_data <= '0;
      o_reg_write  <= 1'b0;
      o_mem_read   <= 1'b0;
      o_mem_write  <= 1'b0;
      o_mem_to_reg <= 1'b0;
      o_rd_addr    <= '0;
      o_overflow   <= 1'b0;
      o_illegal    <= 1'b0;
      o_valid      <= 1'b0;
    end else if (!i_stall) begin
      o_result     <= alu_result;
      o_store_data <= op_bf;
      o_reg_write  <= i_reg_write && !alu_overflow && !alu_illegal;
      o_mem_read   <= i_mem_read && !alu_illegal;
      o_mem_write  <= i_mem_write && !alu_illegal;
      o_mem_to_reg <= i_mem_to_reg;
      o_rd_addr    <= i_rd_addr;
      o_overflow   <= alu_overflow;
      o_illegal    <= alu_illegal;
      o_valid      <= 1'b1;
    end
  end

endmodule

// File: doc/alu_ex_stage.md
# alu_ex_stage

Execute stage of the 5-stage MIPS pipeline. It consumes the 6-bit ALU operation code and shift-amount flag from the ALU control decoder, forwards operands, and computes the ALU result. The result, the overflow/illegal flags and the pass-through memory and writeback controls are registered into the EX/MEM pipeline register, which feeds the memory stage and the forwarding path.

## Interface
- `BITS_DATA`, 32: datapath width.
- `BITS_REG`, 5: register-index width.
- `BITS_IMM`, 16: immediate width.
- `ALU_OP`, 6: ALU operation code width.

Ports:
- `i_clk` in 1: single clock; all state changes on the rising edge.
- `i_reset` in 1: synchronous, active-high reset.
- `i_stall` in 1: hold the EX/MEM register.
- `i_flush` in 1: load a bubble into EX/MEM.
- `i_alu_op` in ALU_OP: operation code from ALU control.
- `i_shamt` in 1: 1 means use the `i_shamt_field` shift amount.
- `i_shamt_field` in 5: instr[10:6].
- `i_alu_src` in 1: 1 means operand B is the extended immediate.
- `i_imm` in BITS_IMM: instr[15:0].
- `i_rs_data`, `i_rt_data` in BITS_DATA: register-file reads.
- `i_wb_data` in BITS_DATA: MEM/WB writeback value.
- `i_fwd_a`, `i_fwd_b` in 2: forwarding selects. 00 = register, 01 = `o_result`, 10 = `i_wb_data`, 11 = register.
- `i_reg_write`, `i_mem_read`, `i_mem_write`, `i_mem_to_reg` in 1: controls passed through.
- `i_rd_addr` in BITS_REG: destination index.
- `o_result` out BITS_DATA: registered ALU result.
- `o_store_data` out BITS_DATA: registered forwarded B, taken before the immediate mux.
- `o_reg_write`, `o_mem_read`, `o_mem_write`, `o_mem_to_reg` out 1: registered controls.
- `o_rd_addr` out BITS_REG: registered destination index.
- `o_overflow` out 1: registered signed overflow.
- `o_illegal` out 1: registered unknown-op flag.
- `o_valid` out 1: EX/MEM holds a real instruction.

## Operation
- Operand A = fwd(`i_fwd_a`, rs).
- Operand Bf = fwd(`i_fwd_b`, rt).
- Operand B = `i_alu_src` ? ext(imm) : Bf.
- Extension rule: ANDI (001100), ORI (001101) and XORI (001110) zero-extend. Every other op sign-extends.
- ADD 100000 and ADDU 100001: A+B.
- SUB 100010 and SUBU 100011: A−B.
- AND 100100 / ANDI: A&B. OR 100101 / ORI: A|B. XOR 100110 / XORI: A^B. NOR 100111: ~(A|B).
- SLT 101010 and SLTI 001010: signed compare A<B, giving 1 or 0.
- Shift source: all shifts operate on Bf.
  - SLL 000000, SRL 000010 and SRA 000011 shift by `i_shamt_field` when `i_shamt`=1.
  - SLLV 000100, SRLV 000110 and SRAV 000111 shift by A[4:0].
  - SRA and SRAV are arithmetic shifts.
- Overflow applies to ADD and SUB only:
  - Detected when the operand signs and the result sign disagree.
  - The result is still registered, `o_overflow`=1 and `o_reg_write` is forced to 0.
  - ADDU and SUBU never flag overflow.
- Any other code, including the decoder's 111111, 111110 and 111101: result = 0, `o_illegal`=1, and `o_reg_write`, `o_mem_write` and `o_mem_read` are forced to 0.
- EX/MEM update priority per edge: `i_reset` > `i_flush` > `i_stall` > load.
  - Reset: all outputs 0.
  - Flush: all controls, `o_valid`, `o_overflow` and `o_illegal` go to 0. Data fields also go to 0.
  - Stall: every output holds its value.
  - Load: the computed values are captured and `o_valid`=1.

## Timing
- Latency is 1 cycle: inputs present before edge N appear on the outputs after edge N.
- Forwarding select 01 reads the current `o_result`, i.e. the previous instruction. This is a combinational loop-free path, because the register output feeds the next computation.
- During a stall, forwarding from `o_result` sees the held value.
- Flush and stall asserted together: the flush wins.
- Reset asserted mid-stall clears the register on that edge.
- Reset value of every output is 0, including `o_valid`=0.

## Structure
- Shared package `alu_defs`:
  - ALU op localparams, matching the ALU control codes.
  - Forwarding-select encodings FWD_REG=00, FWD_EXMEM=01, FWD_MEMWB=10.
- Combinational sub-module `alu_core`:
  - Inputs: A, Bf, B, op, shamt flag, shamt field.
  - Outputs: result, overflow, illegal.
- Forwarding muxes, immediate extension and the EX/MEM register live in the top level.

## Test plan
- ADD with A=0x7FFFFFFF, B=1 → `o_result`=0x80000000, `o_overflow`=1, `o_reg_write`=0. The same operands with ADDU → no overflow and `o_reg_write` passes through.
- ORI with imm 0x8000 and A=0 → 0x00008000. SLTI with imm 0xFFFF and A=0 → 0, because 0 < −1 is false.
- SRA with `i_shamt`=1, field=4 and Bf=0x80000000 → 0xF8000000. SRLV with A=36 (A[4:0]=4) → 0x08000000.
- Back-to-back forwarding:
  - Instruction 1 ADDU 5+3. Instruction 2 uses `i_fwd_a`=01 and ADDU +1 → 9.
  - Instruction 3 uses `i_fwd_b`=10 with `i_wb_data`=0x10 and AND with A=0xFF → 0x10.
- Op 111110 → `o_result`=0, `o_illegal`=1, and reg/mem writes at 0.
- Pipeline control sequence:
  - Load ADD (result 7).
  - Stall 2 cycles: outputs hold 7.
  - Flush and stall together: `o_valid`=0 and all controls at 0.
  - `i_reset` mid-sequence: every output is 0 on the next edge.
